// File: rtl/drv_fifo_pkg.sv
// Shared definitions for the driver-side packet FIFO: default sizes, the
// drop counter width and the occupancy width helper.
package drv_fifo_pkg;

   localparam int def_pckg_sz   = 40;
   localparam int def_deep_fifo = 8;
   localparam int drop_cnt_w    = 8;

   // Request seen on a clock edge, encoded as {push, pop}.
   typedef enum logic [1:0] {
      op_idle = 2'b00,
      op_pop  = 2'b01,
      op_push = 2'b10,
      op_both = 2'b11
   } op_e;

   // Occupancy must represent 0..depth inclusive, hence one extra bit.
   function automatic int occ_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/drv_fifo_if.sv
// Handshake bundle between the packet driver (master) and the FIFO (slave).
interface drv_fifo_if
   import drv_fifo_pkg::*;
#(
   parameter int pckg_sz   = def_pckg_sz,
   parameter int deep_fifo = def_deep_fifo
);

   logic                              push;
   logic [pckg_sz-1:0]                D_push;
   logic                              pop;
   logic [pckg_sz-1:0]                D_pop;
   logic                              pndng;
   logic                              full;
   logic [occ_width(deep_fifo)-1:0]   count;
   logic                              ovf;
   logic                              unf;
   logic [drop_cnt_w-1:0]             drop_cnt;
   logic                              clr_flags;

   modport master (
      output push, D_push, pop, clr_flags,
      input  D_pop, pndng, full, count, ovf, unf, drop_cnt
   );

   modport slave (
      input  push, D_push, pop, clr_flags,
      output D_pop, pndng, full, count, ovf, unf, drop_cnt
   );

endinterface

// File: rtl/drv_fifo_sat_counter.sv
// Saturating up-counter with synchronous clear; an increment in the same
// cycle as a clear restarts the count at one.
module sat_counter
   import drv_fifo_pkg::*;
#(
   parameter int width = drop_cnt_w
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             inc,
   output logic [width-1:0] value
);

   logic [width-1:0] value_r;
   logic [width-1:0] value_nxt_s;

   // Next-count selection: clear, increment, or hold at all-ones.
   always_comb begin
      value_nxt_s = value_r;
      if (inc) begin
         if (clr) begin
            value_nxt_s = width'(1);
         end else if (value_r == {width{1'b1}}) begin
            value_nxt_s = value_r;
         end else begin
            value_nxt_s = value_r + width'(1);
         end
      end else if (clr) begin
         value_nxt_s = {width{1'b0}};
      end else begin
         value_nxt_s = value_r;
      end
   end

   // Count register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         value_r <= {width{1'b0}};
      end else begin
         value_r <= value_nxt_s;
      end
   end

   assign value = value_r;

endmodule

// File: rtl/drv_fifo.sv
// First-word-fall-through circular FIFO between a packet driver and the DUT,
// with sticky overflow/underflow flags and a saturating drop counter.
module drv_fifo
   import drv_fifo_pkg::*;
#(
   parameter int pckg_sz   = def_pckg_sz,
   parameter int deep_fifo = def_deep_fifo
) (
   input  logic        clk,
   input  logic        reset,
   drv_fifo_if.slave   bus
);

   localparam int ptr_w = $clog2(deep_fifo);
   localparam int cnt_w = occ_width(deep_fifo);

   logic [pckg_sz-1:0] mem_r [deep_fifo];
   logic [ptr_w-1:0]   wr_ptr_r;
   logic [ptr_w-1:0]   rd_ptr_r;
   logic [cnt_w-1:0]   count_r;
   logic               ovf_r;
   logic               unf_r;

   op_e                op_s;
   logic               pndng_s;
   logic               full_s;
   logic               do_wr_s;
   logic               do_rd_s;
   logic               ovf_evt_s;
   logic               unf_evt_s;
   logic [cnt_w-1:0]   count_nxt_s;
   logic               ovf_nxt_s;
   logic               unf_nxt_s;

   assign op_s    = op_e'({bus.push, bus.pop});
   assign pndng_s = (count_r != cnt_w'(0));
   assign full_s  = (count_r == cnt_w'(deep_fifo));

   // Decide which side moves this edge; a pop on a full buffer frees the
   // slot the simultaneous push lands in, so no overflow is raised then.
   always_comb begin
      do_wr_s     = 1'b0;
      do_rd_s     = 1'b0;
      ovf_evt_s   = 1'b0;
      unf_evt_s   = 1'b0;
      count_nxt_s = count_r;
      case (op_s)
         op_idle: begin
            count_nxt_s = count_r;
         end
         op_push: begin
            if (full_s) begin
               ovf_evt_s = 1'b1;
            end else begin
               do_wr_s     = 1'b1;
               count_nxt_s = count_r + cnt_w'(1);
            end
         end
         op_pop: begin
            if (pndng_s) begin
               do_rd_s     = 1'b1;
               count_nxt_s = count_r - cnt_w'(1);
            end else begin
               unf_evt_s = 1'b1;
            end
         end
         op_both: begin
            do_wr_s = 1'b1;
            if (pndng_s) begin
               do_rd_s = 1'b1;
            end else begin
               unf_evt_s   = 1'b1;
               count_nxt_s = count_r + cnt_w'(1);
            end
         end
         default: begin
            count_nxt_s = count_r;
         end
      endcase
   end

   // Sticky flags: a new event wins over a same-cycle clear.
   always_comb begin
      if (ovf_evt_s) begin
         ovf_nxt_s = 1'b1;
      end else if (bus.clr_flags) begin
         ovf_nxt_s = 1'b0;
      end else begin
         ovf_nxt_s = ovf_r;
      end
      if (unf_evt_s) begin
         unf_nxt_s = 1'b1;
      end else if (bus.clr_flags) begin
         unf_nxt_s = 1'b0;
      end else begin
         unf_nxt_s = unf_r;
      end
   end

   // Pointers, occupancy and flags; depth is a power of two so the
   // pointers wrap by natural overflow.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_r <= {ptr_w{1'b0}};
         rd_ptr_r <= {ptr_w{1'b0}};
         count_r  <= {cnt_w{1'b0}};
         ovf_r    <= 1'b0;
         unf_r    <= 1'b0;
      end else begin
         if (do_wr_s) begin
            wr_ptr_r <= wr_ptr_r + ptr_w'(1);
         end else begin
            wr_ptr_r <= wr_ptr_r;
         end
         if (do_rd_s) begin
            rd_ptr_r <= rd_ptr_r + ptr_w'(1);
         end else begin
            rd_ptr_r <= rd_ptr_r;
         end
         count_r <= count_nxt_s;
         ovf_r   <= ovf_nxt_s;
         unf_r   <= unf_nxt_s;
      end
   end

   // Storage is deliberately not reset; the output gate hides stale words.
   always_ff @(posedge clk) begin
      if (do_wr_s) begin
         mem_r[wr_ptr_r] <= bus.D_push;
      end
   end

   sat_counter #(.width(drop_cnt_w)) u_drop_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (bus.clr_flags),
      .inc   (ovf_evt_s),
      .value (bus.drop_cnt)
   );

   assign bus.D_pop = pndng_s ? mem_r[rd_ptr_r] : {pckg_sz{1'b0}};
   assign bus.pndng = pndng_s;
   assign bus.full  = full_s;
   assign bus.count = count_r;
   assign bus.ovf   = ovf_r;
   assign bus.unf   = unf_r;

endmodule

// File: doc/drv_fifo.md
DRV_FIFO -- requirements
Module: drv_fifo

Interface
REQ-001 Parameter pckg_sz, default 40, width of one packet word in bits.
REQ-002 Parameter deep_fifo, default 8, storage depth in words; legal values are powers of two from 2 to 256.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 push  input  1  driver-side write strobe, sampled each clk edge.
REQ-006 D_push  input  pckg_sz  packet word written when push is high.
REQ-007 pop  input  1  DUT-side read strobe, sampled each clk edge.
REQ-008 D_pop  output  pckg_sz  head word, first-word-fall-through; 0 when empty.
REQ-009 pndng  output  1  high while at least one word is stored.
REQ-010 full  output  1  high while occupancy equals deep_fifo.
REQ-011 count  output  $clog2(deep_fifo)+1  current occupancy, 0..deep_fifo.
REQ-012 ovf  output  1  sticky flag: a push was dropped.
REQ-013 unf  output  1  sticky flag: a pop arrived while empty.
REQ-014 drop_cnt  output  8  saturating count of dropped pushes.
REQ-015 clr_flags  input  1  synchronous clear of ovf, unf, drop_cnt.

Function
REQ-016 Storage is a circular buffer with wr_ptr and rd_ptr, each $clog2(deep_fifo) bits, wrapping from deep_fifo-1 to 0.
REQ-017 Push while not full: D_push written at wr_ptr, wr_ptr advances, count+1; visible on D_pop the next cycle if buffer was empty.
REQ-018 Pop while pndng: rd_ptr advances, count-1; D_pop shows the next word combinationally after the edge.
REQ-019 Push and pop in the same cycle while 0<count<deep_fifo: both occur, count unchanged.
REQ-020 Push and pop in the same cycle while full: both occur (pop frees the slot), count stays deep_fifo, ovf not set.
REQ-021 Push and pop in the same cycle while empty: push stored, pop ignored, count becomes 1, unf set.
REQ-022 Push while full without pop: word discarded, contents unchanged, ovf set, drop_cnt+1 saturating at 255.
REQ-023 Pop while empty: no pointer change, D_pop stays 0, unf set.
REQ-024 clr_flags clears ovf, unf, drop_cnt at the edge; an overflow/underflow event in the same cycle takes priority and sets its flag, drop_cnt becomes 1.
REQ-025 pndng = (count != 0); full = (count == deep_fifo); both derived from registered count, no extra latency.

Reset
REQ-026 Reset asserted at any time (including mid-transfer) immediately clears wr_ptr, rd_ptr, count, ovf, unf, drop_cnt; pndng=0, full=0, D_pop=0.
REQ-027 Storage array is not reset; stale words are never visible because D_pop is gated by pndng.
REQ-028 push/pop asserted during reset are ignored; first accepted operation is at the first rising clk edge after reset deasserts.

Structure
REQ-029 A shared package holds default pckg_sz (40), default deep_fifo (8), drop counter width (8) and the occupancy width function.
REQ-030 One sub-module sat_counter (parameterised width, inc, clr, saturates at all-ones) implements drop_cnt; the rest is a single flat module.

Verification
REQ-031 Reset, then 8 pushes of 0x01..0x08 -> full=1, count=8, D_pop=0x01, ovf=0.
REQ-032 From full, push 0x09 without pop -> ovf=1, drop_cnt=1, contents unchanged; 8 pops return 0x01..0x08 in order, then pndng=0, D_pop=0.
REQ-033 From full, push 0xAA with pop same cycle -> count=8, ovf=0; draining returns 0x02..0x08 then 0xAA (pointer wrap checked).
REQ-034 Empty, push 0x55 with pop same cycle -> count=1, D_pop=0x55, unf=1; clr_flags -> unf=0.
REQ-035 300 pushes while full -> drop_cnt=255 (saturated), ovf=1; clr_flags with a simultaneous drop -> drop_cnt=1.
REQ-036 Reset asserted asynchronously mid-cycle with count=5 -> count=0, pndng=0, D_pop=0 before next clk edge; next push 0x77 -> D_pop=0x77.
